// File: rtl/text_cell_plotter_if.sv
// Character-write request channel from the editor/cursor logic into text_cell_plotter.
interface text_cell_plotter_if;
   logic       char_valid;
   logic       char_ready;
   logic [6:0] char_code;
   logic [4:0] cell_col;
   logic [2:0] cell_row;
   logic [2:0] fg_colour;

   modport master (output char_valid, char_code, cell_col, cell_row, fg_colour,
                   input  char_ready);
   modport slave  (input  char_valid, char_code, cell_col, cell_row, fg_colour,
                   output char_ready);
endinterface

// File: rtl/text_cell_plotter.sv
// Draws one 8x16 glyph cell into the framebuffer, one pixel per clock, row-major.
// Optional TRANSPARENT_BG_EN: glyph 0-bits are scanned but not plotted.
module text_cell_plotter #(
   parameter int         COLS      = 20,
   parameter int         ROWS      = 7,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic               clk,
   input  logic               resetn,
   text_cell_plotter_if.slave req,
   output logic [6:0]         dec_in,
   input  logic [127:0]       dec_out,
   output logic [7:0]         x,
   output logic [6:0]         y,
   output logic [2:0]         colour,
   output logic               plot,
   output logic               busy
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

   localparam logic [5:0] COLS_LIM = 6'(COLS);
   localparam logic [3:0] ROWS_LIM = 4'(ROWS);

   state_t       state, state_nx;
   logic [6:0]   code_q;
   logic [4:0]   col_q;
   logic [2:0]   row_q;
   logic [2:0]   fg_q;
   logic [127:0] glyph;
   logic [6:0]   pix, pix_nx;
   logic         pixel_slot;
   logic         pix_bit;
   logic         plot_d;
   logic [2:0]   colour_d;
   logic         ready_q;
   logic         accept;
   logic         in_range;

   assign accept         = req.char_valid && ready_q;
   assign in_range       = ({1'b0, col_q} < COLS_LIM) && ({1'b0, row_q} < ROWS_LIM);
   assign req.char_ready = ready_q;
   assign busy           = (state != IDLE);
   assign dec_in         = code_q;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // pix is {r, c}; it always names the pixel currently presented on the outputs,
   // and glyph bit 127-8r-c is simply bit ~pix.
   always_comb begin
      state_nx   = state;
      pix_nx     = pix;
      pixel_slot = 1'b0;
      pix_bit    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = LOAD;
            end
         end
         LOAD: begin
            pix_nx = 7'd0;
            if (in_range) begin
               state_nx   = DRAW;
               pixel_slot = 1'b1;
               pix_bit    = dec_out[127];
            end else begin
               state_nx = IDLE;
            end
         end
         DRAW: begin
            if (pix == 7'd127) begin
               state_nx = IDLE;
            end else begin
               pix_nx     = pix + 7'd1;
               pixel_slot = 1'b1;
               pix_bit    = glyph[~pix_nx];
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef TRANSPARENT_BG_EN
   assign plot_d = pixel_slot & pix_bit;
`else
   assign plot_d = pixel_slot;
`endif
   assign colour_d = pix_bit ? fg_q : BG_COLOUR;

   // Cell origin is a multiple of 8/16, so coordinates are plain concatenations.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pix     <= 7'd0;
         ready_q <= 1'b0;
         code_q  <= 7'd32;
         col_q   <= 5'd0;
         row_q   <= 3'd0;
         fg_q    <= 3'd0;
         glyph   <= 128'd0;
         x       <= 8'd0;
         y       <= 7'd0;
         colour  <= 3'd0;
         plot    <= 1'b0;
      end else begin
         pix     <= pix_nx;
         ready_q <= (state_nx == IDLE);
         plot    <= plot_d;
         if (accept) begin
            code_q <= req.char_code;
            col_q  <= req.cell_col;
            row_q  <= req.cell_row;
            fg_q   <= req.fg_colour;
         end
         if (state == LOAD) begin
            glyph <= dec_out;
         end
         if (pixel_slot) begin
            x      <= {col_q, pix_nx[2:0]};
            y      <= {row_q, pix_nx[6:3]};
            colour <= colour_d;
         end
      end
   end
endmodule
